key_debounce: RTL and testbench

KEY_DEBOUNCE -- requirements
Module: key_debounce

---
 rtl/key_debounce.sv | 122 ++++++++++++
 tb/tb_key_debounce.sv | 136 +++++++++++++
 2 files changed

// File: rtl/key_debounce.sv
// Multi-channel push-button debouncer.
// Each active-low key is synchronized with two flops and must then hold a new
// level for CNT_STABLE consecutive cycles before it is accepted. Accepted
// presses and releases update KEY_OUT and emit single-cycle pulses.
module key_debounce #(
  parameter logic [19:0] CNT_STABLE = 20'd500000,
  parameter int          NKEY       = 4
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic [NKEY-1:0] KEY_IN,
  output logic [NKEY-1:0] KEY_OUT,
  output logic [NKEY-1:0] KEY_PRESS,
  output logic [NKEY-1:0] KEY_REL
);

  localparam logic [1:0] ST_RELEASED     = 2'd0;
  localparam logic [1:0] ST_PRESS_WAIT   = 2'd1;
  localparam logic [1:0] ST_PRESSED      = 2'd2;
  localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;

  // Terminal count: reaching it on the accepting edge gives exactly CNT_STABLE
  // cycles of stable synchronized level.
  localparam logic [19:0] CNT_LAST = CNT_STABLE - 20'd1;

  for (genvar g = 0; g < NKEY; g++) begin : gen_chan
    logic        sync1_q, sync2_q;
    logic [1:0]  state_q, state_d;
    logic [19:0] cnt_q, cnt_d;
    logic        out_q, out_d;
    logic        press_q, press_d;
    logic        rel_q, rel_d;

    // Two-flop synchronizer; idles high to match a released key.
    always_ff @(posedge CLK) begin
      if (!RST_N) begin
        sync1_q <= 1'b1;
        sync2_q <= 1'b1;
      end else begin
        sync1_q <= KEY_IN[g];
        sync2_q <= sync1_q;
      end
    end

    // Debounce next-state: counter restarts on every state change, pulses
    // default low so they last exactly one cycle.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      out_d   = out_q;
      press_d = 1'b0;
      rel_d   = 1'b0;
      case (state_q)
        ST_RELEASED: begin
          if (!sync2_q) begin
            state_d = ST_PRESS_WAIT;
            cnt_d   = 20'd0;
          end
        end
        ST_PRESS_WAIT: begin
          if (sync2_q) begin
            // Bounced back before stable: abandon silently.
            state_d = ST_RELEASED;
            cnt_d   = 20'd0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = ST_PRESSED;
            cnt_d   = 20'd0;
            out_d   = 1'b0;
            press_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 20'd1;
          end
        end
        ST_PRESSED: begin
          if (sync2_q) begin
            state_d = ST_RELEASE_WAIT;
            cnt_d   = 20'd0;
          end
        end
        ST_RELEASE_WAIT: begin
          if (!sync2_q) begin
            state_d = ST_PRESSED;
            cnt_d   = 20'd0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = ST_RELEASED;
            cnt_d   = 20'd0;
            out_d   = 1'b1;
            rel_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + 20'd1;
          end
        end
        default: begin
          state_d = ST_RELEASED;
          cnt_d   = 20'd0;
        end
      endcase
    end

    // Channel state and registered outputs; reset discards any progress.
    always_ff @(posedge CLK) begin
      if (!RST_N) begin
        state_q <= ST_RELEASED;
        cnt_q   <= 20'd0;
        out_q   <= 1'b1;
        press_q <= 1'b0;
        rel_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        out_q   <= out_d;
        press_q <= press_d;
        rel_q   <= rel_d;
      end
    end

    assign KEY_OUT[g]   = out_q;
    assign KEY_PRESS[g] = press_q;
    assign KEY_REL[g]   = rel_q;
  end

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with CNT_STABLE=4, NKEY=4.
// Inputs are driven 1 time unit after a rising edge; outputs are compared
// 1 time unit after the next rising edge.
module tb_key_debounce;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] key_in;
  logic [3:0] key_out, key_press, key_rel;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [3:0] key;
    logic       rst;
    logic [3:0] exp_out;
    logic [3:0] exp_press;
    logic [3:0] exp_rel;
  } vec_t;

  vec_t vecs[$];

  key_debounce #(
    .CNT_STABLE(20'd4),
    .NKEY      (4)
  ) dut (
    .CLK      (clk),
    .RST_N    (rst_n),
    .KEY_IN   (key_in),
    .KEY_OUT  (key_out),
    .KEY_PRESS(key_press),
    .KEY_REL  (key_rel)
  );

  always #5 clk = ~clk;

  task automatic add(input logic [3:0] k, input logic r, input logic [3:0] o,
                     input logic [3:0] p, input logic [3:0] rl, input int n);
    vec_t v;
    v.key = k; v.rst = r; v.exp_out = o; v.exp_press = p; v.exp_rel = rl;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  task automatic tick_check(input string name, input logic [3:0] eo,
                            input logic [3:0] ep, input logic [3:0] er);
    @(posedge clk);
    #1;
    n_cmp++;
    if (key_out !== eo || key_press !== ep || key_rel !== er) begin
      n_bad++;
      $display("FAIL %s: got out=%b press=%b rel=%b, want out=%b press=%b rel=%b",
               name, key_out, key_press, key_rel, eo, ep, er);
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    key_in = 4'hF;

    // Reset, then clean press/release on key 1, then all keys together.
    add(4'hF,    1'b0, 4'hF,    4'h0,    4'h0,    2);
    add(4'hF,    1'b1, 4'hF,    4'h0,    4'h0,    3);
    add(4'b1101, 1'b1, 4'hF,    4'h0,    4'h0,    6);
    add(4'b1101, 1'b1, 4'b1101, 4'b0010, 4'h0,    1);
    add(4'b1101, 1'b1, 4'b1101, 4'h0,    4'h0,    3);
    add(4'hF,    1'b1, 4'b1101, 4'h0,    4'h0,    6);
    add(4'hF,    1'b1, 4'hF,    4'h0,    4'b0010, 1);
    add(4'hF,    1'b1, 4'hF,    4'h0,    4'h0,    3);
    add(4'h0,    1'b1, 4'hF,    4'h0,    4'h0,    6);
    add(4'h0,    1'b1, 4'h0,    4'hF,    4'h0,    1);
    add(4'h0,    1'b1, 4'h0,    4'h0,    4'h0,    3);
    add(4'hF,    1'b1, 4'h0,    4'h0,    4'h0,    6);
    add(4'hF,    1'b1, 4'hF,    4'h0,    4'hF,    1);
    add(4'hF,    1'b1, 4'hF,    4'h0,    4'h0,    3);

    foreach (vecs[i]) begin
      key_in = vecs[i].key;
      rst_n  = vecs[i].rst;
      tick_check($sformatf("vec%0d", i), vecs[i].exp_out, vecs[i].exp_press,
                 vecs[i].exp_rel);
    end

    // Bounce on key 0: low 3, high 2, low held; one press 6 edges after the
    // final fall (edge 5 -> edge 11).
    for (int k = 0; k < 14; k++) begin
      key_in = (k < 3 || k >= 5) ? 4'b1110 : 4'b1111;
      tick_check($sformatf("bounce%0d", k), (k >= 11) ? 4'b1110 : 4'b1111,
                 (k == 11) ? 4'b0001 : 4'b0000, 4'b0000);
    end

    // Two-cycle high glitch while pressed: no release.
    for (int k = 0; k < 10; k++) begin
      key_in = (k < 2) ? 4'b1111 : 4'b1110;
      tick_check($sformatf("glitch%0d", k), 4'b1110, 4'b0000, 4'b0000);
    end

    // Held release of key 0.
    for (int k = 0; k < 8; k++) begin
      key_in = 4'b1111;
      tick_check($sformatf("release%0d", k), (k >= 6) ? 4'b1111 : 4'b1110,
                 4'b0000, (k == 6) ? 4'b0001 : 4'b0000);
    end

    // Key 2 held low; reset lands when its counter is 2.
    for (int k = 0; k < 5; k++) begin
      key_in = 4'b1011;
      tick_check($sformatf("pre_rst%0d", k), 4'hF, 4'h0, 4'h0);
    end
    rst_n = 1'b0;
    tick_check("mid_rst", 4'hF, 4'h0, 4'h0);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick_check($sformatf("post_rst%0d", k), (k >= 6) ? 4'b1011 : 4'b1111,
                 (k == 6) ? 4'b0100 : 4'b0000, 4'b0000);
    end

    // Reset while pressed: no release pulse, then re-acceptance.
    rst_n = 1'b0;
    tick_check("pressed_rst", 4'hF, 4'h0, 4'h0);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick_check($sformatf("reaccept%0d", k), (k >= 6) ? 4'b1011 : 4'b1111,
                 (k == 6) ? 4'b0100 : 4'b0000, 4'b0000);
    end
    for (int k = 0; k < 8; k++) begin
      key_in = 4'hF;
      tick_check($sformatf("rel2_%0d", k), (k >= 6) ? 4'b1111 : 4'b1011,
                 4'b0000, (k == 6) ? 4'b0100 : 4'b0000);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
